// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the shared-transmitter arbiter.
// The slave modport is the arbiter itself. The master modport is the requesters plus uart_tx.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ack;
    logic [ID_W-1:0]         grant_id;
    logic [DATA_W-1:0]       uart_data;
    logic                    uart_start;
    logic                    uart_busy;
    logic                    active;
    logic                    err_timeout;

    modport slave (
        input  req, req_data, req_last, uart_busy,
        output req_ack, grant_id, uart_data, uart_start, active, err_timeout
    );

    modport master (
        output req, req_data, req_last, uart_busy,
        input  req_ack, grant_id, uart_data, uart_start, active, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte requesters.
// A requester can lock the transmitter across a multi-byte message.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_req_ack;
    logic [ID_W-1:0]    r_rr;
    logic [DATA_W-1:0]  r_uart_data;
    logic               r_uart_start;
    logic               r_lock;
    logic               r_err_timeout;
    logic [CNT_W-1:0]   r_cnt;

    logic [DATA_W-1:0]  w_bytes [N_REQ];
    logic               w_hold;
    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    // The round-robin pointer, the reported grant and the lock owner are always
    // the last winner, so a single register serves all three.
    always_comb begin
        w_hold  = r_lock && bus.req[r_rr];
        w_found = 1'b0;
        w_win   = r_rr;
        w_idx   = r_rr;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr) + k) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (w_hold) begin
            w_found = 1'b1;
            w_win   = r_rr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_req_ack     <= '0;
            r_rr          <= '0;
            r_uart_data   <= '0;
            r_uart_start  <= 1'b0;
            r_lock        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_req_ack     <= '0;
            r_uart_start  <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    // An absent lock owner loses its lock implicitly: the search
                    // result already ignores it and the lock is rewritten here.
                    if (!bus.uart_busy && w_found) begin
                        r_uart_data <= w_bytes[w_win];
                        r_req_ack   <= N_REQ'(1) << w_win;
                        r_rr        <= w_win;
                        r_lock      <= ~bus.req_last[w_win];
                        r_state     <= START;
                    end
                end
                START: begin
                    r_uart_start <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.uart_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        r_err_timeout <= 1'b1;
                        r_lock        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.uart_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack     = r_req_ack;
    assign bus.grant_id    = r_rr;
    assign bus.uart_data   = r_uart_data;
    assign bus.uart_start  = r_uart_start;
    assign bus.active      = (r_state != IDLE);
    assign bus.err_timeout = r_err_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a uart_tx stub with loopback capture, directed scenarios,
// then random traffic checked against a grant-order model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // uart_tx stub: busy rises the edge after uart_start and lasts a random frame length.
    logic       stub_en = 1'b1;
    logic       stub_busy = 1'b0;
    int         stub_left = 0;
    logic [7:0] rx_q [$];
    assign bus.uart_busy = stub_busy;

    always @(posedge clk) begin
        if (bus.uart_start && stub_en) begin
            stub_busy <= 1'b1;
            stub_left <= int'($urandom_range(2, 9));
            rx_q.push_back(bus.uart_data);
        end else if (stub_left > 1) begin
            stub_left <= stub_left - 1;
        end else begin
            stub_left <= 0;
            stub_busy <= 1'b0;
        end
    end

    // Pending bytes per requester: {last, data}; head is what is presented on the bus.
    logic [8:0] rq [N][$];
    int         ack_log [$];
    logic [7:0] acc_log [$];

    int   m_rr = 0;
    logic m_lock = 1'b0;
    int   m_lock_id = 0;

    int   cyc = 0;
    int   start_due = -1;
    int   start_cyc = -1;
    int   exp_err_cyc = -1;
    int   err_cyc = -1;
    int   ack_cyc = -1;
    int   fall_cyc = -1;
    logic [7:0] last_byte = 8'h00;
    logic prev_busy = 1'b0;
    logic gap_en = 1'b0;
    logic gap_flag = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Winner = locked owner if still requesting, else the pending requester
    // closest after the last winner in circular order.
    function automatic int predict(input logic [N-1:0] p);
        int best;
        int bestd;
        int d;
        if (m_lock && ((p >> m_lock_id) & N'(1)) != '0) return m_lock_id;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (((p >> i) & N'(1)) != '0) begin
                d = (i - m_rr - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic push(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back({last, d});
    endtask

    task automatic drive();
        logic [N-1:0]    r;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        r = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                r[i]           = 1'b1;
                l[i]           = rq[i][0][8];
                d[i*DW +: DW]  = rq[i][0][7:0];
            end
        end
        bus.req      = r;
        bus.req_last = l;
        bus.req_data = d;
    endtask

    task automatic cycle();
        logic [N-1:0] pend;
        int   nack;
        int   id;
        logic [8:0] head;
        pend = bus.req;
        @(posedge clk);
        #1;
        cyc++;
        nack = $countones(bus.req_ack);
        chk("ack_onehot", 32'(nack <= 1), 1);
        if (nack == 1) begin
            id = 0;
            for (int i = 0; i < N; i++) if (bus.req_ack[i]) id = i;
            chk("ack_id", id, predict(pend));
            chk("ack_pending", 32'(pend[id]), 1);
            chk("grant_id", 32'(bus.grant_id), id);
            if (rq[id].size() > 0) begin
                head = rq[id].pop_front();
                chk("ack_data", 32'(bus.uart_data), 32'(head[7:0]));
                last_byte = head[7:0];
                acc_log.push_back(head[7:0]);
                m_lock    = !head[8];
            end
            m_rr      = id;
            m_lock_id = id;
            ack_log.push_back(id);
            start_due = cyc + 1;
            ack_cyc   = cyc;
            if (gap_flag) begin
                chk("idle_gap", cyc - fall_cyc, 2);
                gap_flag = 1'b0;
            end
        end else begin
            chk("data_hold", 32'(bus.uart_data), 32'(last_byte));
        end
        chk("uart_start", 32'(bus.uart_start), 32'(start_due == cyc));
        if (bus.uart_start) begin
            chk("start_data", 32'(bus.uart_data), 32'(last_byte));
            start_cyc = cyc;
            if (!stub_en) begin
                exp_err_cyc = cyc + BT;
                m_lock      = 1'b0;
            end
        end
        chk("err_timeout", 32'(bus.err_timeout), 32'(exp_err_cyc == cyc));
        if (bus.err_timeout) err_cyc = cyc;
        if (prev_busy && !bus.uart_busy) fall_cyc = cyc;
        prev_busy = bus.uart_busy;
        drive();
        if (gap_en && fall_cyc == cyc && bus.req != '0) gap_flag = 1'b1;
    endtask

    function automatic logic quiet();
        logic q;
        q = !bus.active && !bus.uart_busy;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) q = 1'b0;
        return q;
    endfunction

    task automatic wait_drain(input string tag, input int max);
        for (int k = 0; k < max && !quiet(); k++) cycle();
        chk({tag, "_drain"}, 32'(quiet()), 1);
    endtask

    task automatic check_log(input string tag, input int n_ids, input logic [31:0] ids,
                             input int n_rx, input logic [63:0] rx);
        chk({tag, "_acks"}, ack_log.size(), n_ids);
        for (int i = 0; i < n_ids && i < ack_log.size(); i++)
            chk({tag, "_grant"}, ack_log[i], (ids >> (4 * i)) & 32'hF);
        chk({tag, "_rxn"}, rx_q.size(), n_rx);
        for (int i = 0; i < n_rx && i < rx_q.size(); i++)
            chk({tag, "_rx"}, 32'(rx_q[i]), 32'((rx >> (8 * i)) & 64'hFF));
        ack_log.delete();
        acc_log.delete();
        rx_q.delete();
    endtask

    task automatic model_reset();
        m_rr        = 0;
        m_lock      = 1'b0;
        m_lock_id   = 0;
        start_due   = -1;
        exp_err_cyc = -1;
        last_byte   = 8'h00;
        gap_flag    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},    32'(bus.req_ack), 0);
        chk({tag, "_start"},  32'(bus.uart_start), 0);
        chk({tag, "_data"},   32'(bus.uart_data), 0);
        chk({tag, "_grant"},  32'(bus.grant_id), 0);
        chk({tag, "_active"}, 32'(bus.active), 0);
        chk({tag, "_err"},    32'(bus.err_timeout), 0);
    endtask

    initial begin
        drive();
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset");
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // Single byte: ack one edge after req, start one edge after ack.
        push(0, 8'h55, 1'b1);
        drive();
        begin
            int req_cyc;
            req_cyc = cyc;
            wait_drain("single", 100);
            chk("single_latency", ack_cyc - req_cyc, 1);
            chk("single_start_lat", start_cyc - ack_cyc, 1);
        end
        chk("single_active", 32'(bus.active), 0);
        check_log("single", 1, 32'h0, 1, 64'h55);

        // Contention: all four requesters, rr starts after requester 0.
        for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
        drive();
        wait_drain("contend", 300);
        check_log("contend", 4, 32'h0321, 4, 64'h10131211);

        // Lock: requester 2 keeps the transmitter for its two-byte message.
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b1);
        drive();
        cycle();
        push(1, 8'hC1, 1'b1);
        drive();
        wait_drain("lock", 300);
        check_log("lock", 3, 32'h122, 3, 64'hC1A2A1);

        // Lock abandon: requester 2 drops after a last=0 byte, requester 0 proceeds.
        push(2, 8'hB0, 1'b0);
        push(0, 8'h0D, 1'b1);
        drive();
        wait_drain("abandon", 300);
        check_log("abandon", 2, 32'h02, 2, 64'h0DB0);

        // Timeout: busy never rises; lock taken by 0x77 must be released.
        stub_en = 1'b0;
        push(1, 8'h77, 1'b0);
        drive();
        wait_drain("timeout", 100);
        chk("timeout_latency", err_cyc - start_cyc, BT);
        cycle();
        stub_en = 1'b1;
        push(1, 8'h78, 1'b1);
        push(3, 8'h33, 1'b1);
        drive();
        wait_drain("after_timeout", 300);
        check_log("timeout", 3, 32'h131, 2, 64'h7833);

        // Reset mid-frame: outputs clear without a clock edge; frame in uart_tx continues.
        push(0, 8'h99, 1'b1);
        drive();
        for (int k = 0; k < 60 && !bus.uart_busy; k++) cycle();
        chk("busy_rose", 32'(bus.uart_busy), 1);
        cycle();
        chk("pre_reset_active", 32'(bus.active), 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
        push(2, 8'h3C, 1'b1);
        drive();
        wait_drain("post_reset", 300);
        check_log("post_reset", 2, 32'h20, 2, 64'h3C99);

        // Random traffic against the grant-order model.
        gap_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            int ri;
            cycle();
            if ($urandom_range(0, 2) == 0) begin
                ri = int'($urandom_range(0, N - 1));
                if (rq[ri].size() < 3) begin
                    push(ri, 8'($urandom), $urandom_range(0, 9) < 7);
                    drive();
                end
            end
        end
        wait_drain("random", 3000);
        chk("random_rxn", rx_q.size(), acc_log.size());
        for (int i = 0; i < acc_log.size() && i < rx_q.size(); i++)
            chk("random_rx", 32'(rx_q[i]), 32'(acc_log[i]));
        chk("random_some", 32'(acc_log.size() > 50), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
